// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: state geometry and GF(2^8) constant multipliers.
package aes_pkg;

    localparam int unsigned STATE_W  = 128;
    localparam int unsigned COL_W    = 32;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned NUM_COLS = STATE_W / COL_W;
    localparam int unsigned NUM_ROWS = COL_W / BYTE_W;

    localparam logic [BYTE_W-1:0] GF_POLY = 8'h1B;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    endfunction

    // Multiply by one of the MixColumns coefficients {1,2,3,9,b,d,e}.
    // Built from an xtime chain (2x, 4x, 8x) plus XOR; any other code passes x through.
    function automatic logic [BYTE_W-1:0] gf_mul_const(input logic [BYTE_W-1:0] x,
                                                       input logic [3:0]        c);
        logic [BYTE_W-1:0] x2;
        logic [BYTE_W-1:0] x4;
        logic [BYTE_W-1:0] x8;
        logic [BYTE_W-1:0] r;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (c)
            4'h2:    r = x2;
            4'h3:    r = x2 ^ x;
            4'h9:    r = x8 ^ x;
            4'hB:    r = x8 ^ x2 ^ x;
            4'hD:    r = x8 ^ x4 ^ x;
            4'hE:    r = x8 ^ x4 ^ x2;
            default: r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column.
// Ports:
//   inv       - 0 = forward MixColumns, 1 = InvMixColumns
//   col       - input column, row 0 in bits [31:24]
//   col_mix_c - transformed column, same byte order
module mix_column_word
    import aes_pkg::*;
(
    input  logic             inv,
    input  logic [COL_W-1:0] col,
    output logic [COL_W-1:0] col_mix_c
);

    // Both matrices are circulant: row r uses the base row rotated right by r,
    // so the coefficient for input byte j of output row r is base[(j - r) mod 4].
    function automatic logic [3:0] coef_sel(input logic mode, input logic [1:0] k);
        logic [3:0] c;
        if (mode) begin
            case (k)
                2'd0:    c = 4'hE;
                2'd1:    c = 4'hB;
                2'd2:    c = 4'hD;
                default: c = 4'h9;
            endcase
        end else begin
            case (k)
                2'd0:    c = 4'h2;
                2'd1:    c = 4'h3;
                default: c = 4'h1;
            endcase
        end
        return c;
    endfunction

    logic [BYTE_W-1:0] a [NUM_ROWS];
    logic [BYTE_W-1:0] b [NUM_ROWS];

    // Split column into bytes, row 0 most significant.
    always_comb begin
        for (int j = 0; j < int'(NUM_ROWS); j++) begin
            a[j] = col[COL_W-1-BYTE_W*j -: BYTE_W];
        end
    end

    // Matrix-vector product over GF(2^8).
    always_comb begin
        for (int r = 0; r < int'(NUM_ROWS); r++) begin
            b[r] = '0;
            for (int j = 0; j < int'(NUM_ROWS); j++) begin
                b[r] = b[r] ^ gf_mul_const(a[j], coef_sel(inv, 2'(j - r)));
            end
        end
    end

    assign col_mix_c = {b[0], b[1], b[2], b[3]};

endmodule

// File: rtl/mix_columns.sv
// Registered AES MixColumns / InvMixColumns stage, one state per cycle, one-cycle latency.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   in_valid  - state_in / inv valid this cycle
//   inv       - 0 = MixColumns, 1 = InvMixColumns
//   state_in  - 128-bit input state, byte 0 in bits [127:120]
//   out_valid - state_out holds a new result this cycle
//   state_out - transformed state, held while no new input arrives
module mix_columns
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               inv,
    input  logic [STATE_W-1:0] state_in,
    output logic               out_valid,
    output logic [STATE_W-1:0] state_out
);

    logic [STATE_W-1:0] mixed_c;

    // Four independent column transforms; column c sits at bits [127-32c -: 32].
    for (genvar c = 0; c < int'(NUM_COLS); c++) begin : g_col
        mix_column_word u_col (
            .inv       (inv),
            .col       (state_in[STATE_W-1-COL_W*c -: COL_W]),
            .col_mix_c (mixed_c[STATE_W-1-COL_W*c -: COL_W])
        );
    end

    // Output register: capture on valid, otherwise hold data and drop valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            state_out <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                state_out <= mixed_c;
            end
        end
    end

endmodule

// File: tb/tb_mix_columns.sv
// Self-checking bench for mix_columns: scoreboard queue fed at drive time, drained by a monitor.
module tb_mix_columns;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         inv;
    logic [127:0] state_in;
    logic         out_valid;
    logic [127:0] state_out;

    int tests_run = 0;
    int tests_failed = 0;

    logic [127:0] exp_q[$];
    logic [127:0] last_exp;
    logic         sent;

    mix_columns dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inv       (inv),
        .state_in  (state_in),
        .out_valid (out_valid),
        .state_out (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference multiply: shift-and-add over GF(2^8).
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00;
        aa = x;
        bb = y;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Reference state transform using explicit 4x4 coefficient matrices.
    function automatic logic [127:0] model(input logic [127:0] s, input logic m);
        logic [127:0] tbl;
        logic [127:0] r;
        logic [7:0]   acc;
        tbl = m ? 128'h0e0b0d09_090e0b0d_0d090e0b_0b0d090e
                : 128'h02030101_01020301_01010203_03010102;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(s[127-32*c-8*j -: 8], tbl[127-8*(4*row+j) -: 8]);
                end
                r[127-32*c-8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Tracks which cycles should produce a result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sent <= 1'b0;
        else        sent <= in_valid;
    end

    // Monitor: checks valid timing every cycle and pops the scoreboard on each result.
    always @(negedge clk) begin
        if (rst_n) begin
            tests_run++;
            if (out_valid !== sent) begin
                tests_failed++;
                $display("FAIL out_valid_timing: got %b expected %b at %0t", out_valid, sent, $time);
            end
            if (sent) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL scoreboard_underflow: got %h with no expected entry", state_out);
                end else begin
                    logic [127:0] e;
                    e = exp_q.pop_front();
                    if (state_out !== e) begin
                        tests_failed++;
                        $display("FAIL state_out: got %h expected %h at %0t", state_out, e, $time);
                    end
                end
            end
        end
    end

    task automatic send(input logic [127:0] s, input logic m, input logic [127:0] e);
        @(negedge clk);
        in_valid = 1'b1;
        inv      = m;
        state_in = s;
        exp_q.push_back(e);
        last_exp = e;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            state_in = {$urandom, $urandom, $urandom, $urandom};
            inv      = 1'($urandom);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            inv      = 1'($urandom);
            state_in = {$urandom, $urandom, $urandom, $urandom};
            #1;
            tests_run++;
            if (out_valid !== 1'b0 || state_out !== 128'h0) begin
                tests_failed++;
                $display("FAIL reset_hold: got v=%b d=%h expected v=0 d=0", out_valid, state_out);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        idle(2);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || state_out !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got v=%b d=%h expected v=0 d=0", out_valid, state_out);
        end
    endtask

    task automatic test_vectors;
        send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c);
        idle(1);
        send(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
        send(128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff);
        send(128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        idle(2);
    endtask

    task automatic test_round_trip;
        logic [127:0] s;
        logic [127:0] f;
        for (int i = 0; i < 8; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            f = model(s, 1'b0);
            send(s, 1'b0, f);
            send(f, 1'b1, s);
        end
        idle(2);
    endtask

    task automatic test_back_to_back;
        logic [127:0] s0;
        logic [127:0] s1;
        logic [127:0] s2;
        s0 = {$urandom, $urandom, $urandom, $urandom};
        s1 = {$urandom, $urandom, $urandom, $urandom};
        s2 = {$urandom, $urandom, $urandom, $urandom};
        send(s0, 1'b0, model(s0, 1'b0));
        send(s1, 1'b1, model(s1, 1'b1));
        send(s2, 1'b0, model(s2, 1'b0));
        idle(1);
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || state_out !== last_exp) begin
            tests_failed++;
            $display("FAIL idle_hold: got v=%b d=%h expected v=0 d=%h", out_valid, state_out, last_exp);
        end
        idle(2);
    endtask

    task automatic test_reset_mid_stream;
        logic [127:0] s;
        s = {$urandom, $urandom, $urandom, $urandom};
        send(s, 1'b1, model(s, 1'b1));
        @(posedge clk);
        #2;
        tests_run++;
        if (out_valid !== 1'b1 || state_out !== last_exp) begin
            tests_failed++;
            $display("FAIL pre_reset_out: got v=%b d=%h expected v=1 d=%h", out_valid, state_out, last_exp);
        end
        // In-flight result is discarded by reset.
        exp_q.delete();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || state_out !== 128'h0) begin
            tests_failed++;
            $display("FAIL async_reset_clear: got v=%b d=%h expected v=0 d=0", out_valid, state_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        s = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        send(s, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c);
        idle(3);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        inv      = 1'b0;
        state_in = '0;
        last_exp = '0;
        test_reset;
        test_vectors;
        test_round_trip;
        test_back_to_back;
        test_reset_mid_stream;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mix_columns.md
# mix_columns

Registered AES MixColumns / InvMixColumns stage for the AES-128 datapath. It transforms a 128-bit state column by column using GF(2^8) matrix multiplication. It sits between ShiftRows and AddRoundKey in the encrypt round, and between AddRoundKey and InvShiftRows in the decrypt round. One state is accepted per cycle, with a fixed one-cycle latency.

## Interface
Parameters: none.

Ports:
- clk  input  1  rising-edge clock, the block's only clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  state_in and inv are valid this cycle.
- inv  input  1  mode select: 0 = MixColumns (encrypt), 1 = InvMixColumns (decrypt).
- state_in  input  128  input state.
- out_valid  output  1  state_out holds a new result.
- state_out  output  128  transformed state.

## Operation
- Byte mapping:
  - byte k = state_in[127-8k -: 8], for k = 0..15.
  - Column c = bytes 4c..4c+3, with row 0 in the most significant byte.
  - Column c therefore occupies bits [127-32c -: 32].
- Forward mode (inv=0), per column (a0..a3 → b0..b3), all arithmetic in GF(2^8) with modulus x^8+x^4+x^3+x+1 (0x11B):
  - b0 = 2a0 ^ 3a1 ^ a2 ^ a3
  - b1 = a0 ^ 2a1 ^ 3a2 ^ a3
  - b2 = a0 ^ a1 ^ 2a2 ^ 3a3
  - b3 = 3a0 ^ a1 ^ a2 ^ 2a3
- Inverse mode (inv=1): same structure with coefficient rows {0e,0b,0d,09}, {09,0e,0b,0d}, {0d,09,0e,0b}, {0b,0d,09,0e}.
- Multiplication rules:
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
  - 3x = xtime(x)^x.
  - 9, 0b, 0d and 0e are built from repeated xtime plus XOR. No LUT ROM.
- All four columns are computed in parallel, combinationally, from state_in and inv.
- The result is captured in the output register.
- Round-trip property: inverse(forward(s)) = s for every s.

## Timing
- Reset (rst_n low, asynchronous): state_out = 128'h0, out_valid = 0. Both hold until the first valid input after rst_n rises.
- Latency is one cycle:
  - If in_valid = 1 at rising edge N, state_out = f(state_in, inv) and out_valid = 1 after edge N.
- If in_valid = 0 at an edge: out_valid = 0 and state_out holds its previous value.
- Throughput: one state per cycle. Back-to-back valid inputs each produce a result on consecutive cycles. There is no backpressure.
- inv is sampled with state_in on the same edge. Mode may change every cycle with no bubble.
- Reset asserted mid-stream: any in-flight result is discarded and outputs clear immediately. The first valid input after deassertion is processed normally.

## Structure
- Shared package aes_pkg:
  - STATE_W = 128.
  - GF_POLY = 8'h1B.
  - Functions xtime and gf_mul_const (constants 2, 3, 9, b, d, e).
- Sub-module mix_column_word: a combinational 32-bit column transform with an inv input.
  - Instantiated four times.
  - The top level holds only the output and valid registers.

## Test plan
- Reset: rst_n=0 with random inputs → state_out=0, out_valid=0. After release with in_valid=0, outputs stay at 0.
- Forward FIPS-197 vector: state_in=d4bf5d30e0b452aeb84111f11e2798e5, inv=0 → state_out=046681e5e0cb199a48f8d37a2806264c one cycle later, out_valid=1.
- Column vectors, forward, state db135345_f20a225c_01010101_c6c6c6c6 → 8e4da1bc_9fdc589d_01010101_c6c6c6c6; state d4d4d4d5_2d26314c_00000000_ffffffff → d5d5d7d6_4d7ebdf8_00000000_ffffffff.
- Inverse: state_in=046681e5e0cb199a48f8d37a2806264c, inv=1 → d4bf5d30e0b452aeb84111f11e2798e5. Random states forward then inverse must return the original.
- Streaming: three back-to-back valid inputs alternating inv → three consecutive correct outputs. Then in_valid=0 → out_valid=0 and state_out held.
- Reset mid-stream: assert rst_n low between clock edges while out_valid=1 → outputs clear at once without waiting for a clock edge.
